// File: rtl/load_store_queue.sv
// load_store_queue: in-order memory-op queue; loads issue freely, stores wait for the ROB head, load results go out through a one-entry CDB slot.
module load_store_queue #(
  parameter int DEPTH = 4,
  parameter int ROB_IX_W = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                enq_valid_in,
  input  logic                enq_is_store_in,
  input  logic [ROB_IX_W-1:0] enq_rob_ix_in,
  input  logic [31:0]         enq_addr_in,
  input  logic [31:0]         enq_data_in,
  output logic                enq_ready_out,
  input  logic [ROB_IX_W-1:0] rob_head_ix_in,
  input  logic                flush_in,
  output logic                mem_valid_out,
  input  logic                mem_ready_in,
  output logic                mem_load_or_store_out,
  output logic [ROB_IX_W-1:0] mem_load_rob_ix_out,
  output logic [31:0]         mem_load_addr_out,
  output logic [31:0]         mem_store_addr_out,
  output logic [31:0]         mem_store_data_out,
  input  logic                mem_result_valid_in,
  input  logic [ROB_IX_W-1:0] mem_result_rob_ix_in,
  input  logic [31:0]         mem_result_data_in,
  output logic                mem_read_out,
  output logic                cdb_valid_out,
  output logic [ROB_IX_W-1:0] cdb_rob_ix_out,
  output logic [31:0]         cdb_data_out,
  input  logic                cdb_ready_in
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN} state_t;
  state_t state, state_nxt;
  logic [AW:0] head, tail;
  logic [AW-1:0] h;
  logic q_store [DEPTH];
  logic [ROB_IX_W-1:0] q_rob [DEPTH];
  logic [31:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [ROB_IX_W-1:0] hold_rob;
  logic [31:0] hold_addr;
  logic empty, full, enq, fire, load_fire, slot_free, load_done;

  assign h = head[AW-1:0];
  assign empty = head == tail;
  assign full = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign enq_ready_out = !full;
  assign enq = enq_valid_in && !full && !flush_in;
  assign slot_free = !cdb_valid_out || cdb_ready_in;
  assign fire = mem_valid_out && mem_ready_in;
  assign load_fire = fire && !q_store[h];
  assign load_done = mem_read_out && state == LOAD_WAIT && !flush_in;
  assign mem_store_addr_out = q_addr[h];
  assign mem_store_data_out = q_data[h];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else state <= state_nxt;
  end

  // After a load fires, the address is held so the memory unit sees it stable until the result is read.
  always_comb begin
    state_nxt = state;
    mem_valid_out = 1'b0;
    mem_load_or_store_out = 1'b0;
    mem_read_out = 1'b0;
    mem_load_addr_out = hold_addr;
    mem_load_rob_ix_out = hold_rob;
    case (state)
      IDLE: begin
        mem_valid_out = !empty && (!q_store[h] || q_rob[h] == rob_head_ix_in);
        mem_load_or_store_out = !empty && q_store[h];
        mem_load_addr_out = q_addr[h];
        mem_load_rob_ix_out = q_rob[h];
        if (mem_valid_out && mem_ready_in && !q_store[h]) state_nxt = flush_in ? DRAIN : LOAD_WAIT;
      end
      LOAD_WAIT: begin
        mem_read_out = mem_result_valid_in && slot_free;
        state_nxt = mem_read_out ? IDLE : flush_in ? DRAIN : LOAD_WAIT;
      end
      DRAIN: begin
        mem_read_out = mem_result_valid_in;
        state_nxt = mem_result_valid_in ? IDLE : DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head <= '0;
      tail <= '0;
      hold_addr <= '0;
      hold_rob <= '0;
      cdb_valid_out <= 1'b0;
      cdb_rob_ix_out <= '0;
      cdb_data_out <= '0;
    end else begin
      if (flush_in) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (fire) head <= head + (AW+1)'(1);
        if (enq) tail <= tail + (AW+1)'(1);
      end
      if (load_fire) begin
        hold_addr <= q_addr[h];
        hold_rob <= q_rob[h];
      end
      if (flush_in) cdb_valid_out <= 1'b0;
      else if (load_done) begin
        cdb_valid_out <= 1'b1;
        cdb_rob_ix_out <= mem_result_rob_ix_in;
        cdb_data_out <= mem_result_data_in;
      end else if (cdb_ready_in) cdb_valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq) begin
      q_store[tail[AW-1:0]] <= enq_is_store_in;
      q_rob[tail[AW-1:0]] <= enq_rob_ix_in;
      q_addr[tail[AW-1:0]] <= enq_addr_in;
      q_data[tail[AW-1:0]] <= enq_data_in;
    end
  end
endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue: memory-unit model plus a program-order reference memory feeding a CDB result scoreboard.
module tb_load_store_queue;
  localparam int DEPTH = 4;
  localparam int RW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic enq_valid = 1'b0, enq_is_store = 1'b0, flush = 1'b0, cdb_ready = 1'b1, ready_en = 1'b1, auto_head = 1'b0;
  logic [RW-1:0] enq_rob = '0, man_head = '0, head_ix = '0;
  logic [31:0] enq_addr = '0, enq_data = '0;
  logic [RW-1:0] rob_head, mem_load_rob, mem_rrob, cdb_rob;
  logic enq_ready, mem_valid, mem_ready, mem_ls, mem_read, cdb_valid, mem_rvalid, busy;
  logic [31:0] mem_load_addr, mem_store_addr, mem_store_data, mem_rdata, cdb_data;
  logic [1:0] cnt;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  typedef struct packed {logic [RW-1:0] rob; logic [31:0] data;} res_t;
  res_t exp_q [$];
  logic [RW-1:0] pend [$];
  int vectors = 0, errors = 0;

  assign rob_head = auto_head ? head_ix : man_head;
  assign mem_ready = ready_en && !busy;

  load_store_queue #(.DEPTH(DEPTH), .ROB_IX_W(RW)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .enq_valid_in(enq_valid), .enq_is_store_in(enq_is_store), .enq_rob_ix_in(enq_rob),
    .enq_addr_in(enq_addr), .enq_data_in(enq_data), .enq_ready_out(enq_ready),
    .rob_head_ix_in(rob_head), .flush_in(flush),
    .mem_valid_out(mem_valid), .mem_ready_in(mem_ready), .mem_load_or_store_out(mem_ls),
    .mem_load_rob_ix_out(mem_load_rob), .mem_load_addr_out(mem_load_addr),
    .mem_store_addr_out(mem_store_addr), .mem_store_data_out(mem_store_data),
    .mem_result_valid_in(mem_rvalid), .mem_result_rob_ix_in(mem_rrob), .mem_result_data_in(mem_rdata),
    .mem_read_out(mem_read),
    .cdb_valid_out(cdb_valid), .cdb_rob_ix_out(cdb_rob), .cdb_data_out(cdb_data), .cdb_ready_in(cdb_ready)
  );

  function automatic logic [31:0] init_val(int i);
    return i == 2 ? 32'h1234 : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Memory unit: load result valid three cycles after fire, held until read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= 2'd0;
      mem_rvalid <= 1'b0;
      mem_rrob <= '0;
      mem_rdata <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_rvalid && mem_read) begin
      mem_rvalid <= 1'b0;
      busy <= 1'b0;
    end else if (busy && !mem_rvalid) begin
      cnt <= cnt + 2'd1;
      if (cnt == 2'd1) mem_rvalid <= 1'b1;
    end else if (mem_valid && mem_ready) begin
      if (mem_ls) mem[mem_store_addr[7:2]] <= mem_store_data;
      else begin
        busy <= 1'b1;
        cnt <= 2'd0;
        mem_rrob <= mem_load_rob;
        mem_rdata <= mem[mem_load_addr[7:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Scoreboard: a load's value is the reference memory after all earlier stores in program order.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        pend.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
      end else begin
        if (cdb_valid && cdb_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL cdb_unexpected: got rob %0d data %h, expected no result", cdb_rob, cdb_data);
          end else begin
            e = exp_q.pop_front();
            check("cdb_rob", 32'(cdb_rob), 32'(e.rob));
            check("cdb_data", cdb_data, e.data);
          end
          if (pend.size() != 0) void'(pend.pop_front());
        end
        if (flush) begin
          exp_q.delete();
          pend.delete();
        end else if (enq_valid && enq_ready) begin
          pend.push_back(enq_rob);
          if (enq_is_store) ref_mem[enq_addr[7:2]] = enq_data;
          else exp_q.push_back('{rob: enq_rob, data: ref_mem[enq_addr[7:2]]});
        end
        if (mem_valid && mem_ready && mem_ls && pend.size() != 0) void'(pend.pop_front());
      end
    end
  end

  // ROB head tracks the oldest op that has not completed.
  initial forever begin
    @(posedge clk);
    #1;
    head_ix = pend.size() != 0 ? pend[0] : '0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic st, input logic [RW-1:0] rob, input logic [31:0] a, input logic [31:0] d);
    enq_valid = 1'b1;
    enq_is_store = st;
    enq_rob = rob;
    enq_addr = a;
    enq_data = d;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic wait_cdb(output int cyc, output int reads, output int read_at);
    cyc = 0;
    reads = 0;
    read_at = -1;
    while (!cdb_valid && cyc < 20) begin
      tick();
      cyc++;
      @(negedge clk);
      if (mem_read) begin
        reads++;
        read_at = cyc;
      end
    end
  endtask

  task automatic wait_blocked();
    int n = 0;
    @(negedge clk);
    while (!(mem_rvalid && cdb_valid) && n < 30) begin
      tick();
      n++;
      @(negedge clk);
    end
    check("blocked_reached", 32'(mem_rvalid && cdb_valid), 32'd1);
  endtask

  initial begin
    int cyc, reads, read_at, mv, nr, cdbs;
    logic acc;
    logic [RW-1:0] next_rob;
    @(negedge clk);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    man_head = 3'd3;
    // single load
    enq(1'b0, 3'd2, 32'h8, 32'd0);
    @(negedge clk);
    check("ld_fire", 32'(mem_valid && !mem_ls), 32'd1);
    check("ld_addr", mem_load_addr, 32'h8);
    wait_cdb(cyc, reads, read_at);
    check("ld_latency", 32'(cyc), 32'd4);
    check("ld_reads", 32'(reads), 32'd1);
    check("ld_read_at", 32'(read_at), 32'd3);
    check("ld_cdb_rob", 32'(cdb_rob), 32'd2);
    check("ld_cdb_data", cdb_data, 32'h1234);
    tick();
    // store gated by ROB head
    enq(1'b1, 3'd5, 32'h4, 32'hAA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_wait", 32'(mem_valid), 32'd0);
      tick();
    end
    man_head = 3'd5;
    @(negedge clk);
    check("st_fire", 32'(mem_valid && mem_ready && mem_ls), 32'd1);
    check("st_addr", mem_store_addr, 32'h4);
    check("st_data", mem_store_data, 32'hAA);
    tick();
    @(negedge clk);
    check("st_once", 32'(mem_valid), 32'd0);
    tick();
    enq(1'b0, 3'd6, 32'h4, 32'd0);
    @(negedge clk);
    wait_cdb(cyc, reads, read_at);
    check("st_ld_data", cdb_data, 32'hAA);
    tick();
    // fill to full with the memory unit stalled
    ready_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1;
      enq_is_store = 1'b0;
      enq_rob = 3'(i);
      enq_addr = 32'h10 + 32'(4 * i);
      @(negedge clk);
      check("fill_ready", 32'(enq_ready), 32'd1);
      tick();
    end
    enq_rob = 3'd4;
    enq_addr = 32'h30;
    @(negedge clk);
    check("fill_full", 32'(enq_ready), 32'd0);
    tick();
    enq_valid = 1'b0;
    ready_en = 1'b1;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || cdb_valid); i++) tick();
    check("fill_drain", 32'(exp_q.size()), 32'd0);
    // CDB backpressure
    cdb_ready = 1'b0;
    enq(1'b0, 3'd1, 32'h20, 32'd0);
    enq(1'b0, 3'd2, 32'h24, 32'd0);
    wait_blocked();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        tick();
        @(negedge clk);
      end
      check("bp_no_read", 32'(mem_read), 32'd0);
      check("bp_hold_rob", 32'(cdb_rob), 32'd1);
    end
    tick();
    cdb_ready = 1'b1;
    @(negedge clk);
    check("bp_release_read", 32'(mem_read), 32'd1);
    tick();
    @(negedge clk);
    check("bp_refill_rob", 32'(cdb_valid ? cdb_rob : 3'd7), 32'd2);
    tick();
    @(negedge clk);
    check("bp_no_dup", 32'(cdb_valid), 32'd0);
    tick();
    // flush one cycle after a load fires, two entries behind it
    ready_en = 1'b0;
    enq(1'b0, 3'd3, 32'h2C, 32'd0);
    enq(1'b0, 3'd4, 32'h30, 32'd0);
    enq(1'b0, 3'd5, 32'h34, 32'd0);
    ready_en = 1'b1;
    @(negedge clk);
    check("fl_fire", 32'(mem_valid && mem_ready), 32'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("fl_wait", 32'(mem_valid), 32'd0);
    tick();
    flush = 1'b0;
    reads = 0;
    read_at = -1;
    mv = 0;
    nr = 0;
    cdbs = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_read) begin
        reads++;
        read_at = i;
      end
      if (cdb_valid) cdbs++;
      if (mem_valid) mv++;
      if (!enq_ready) nr++;
      tick();
    end
    check("fl_reads", 32'(reads), 32'd1);
    check("fl_read_at", 32'(read_at), 32'd2);
    check("fl_no_cdb", 32'(cdbs), 32'd0);
    check("fl_empty", 32'(mv), 32'd0);
    check("fl_ready", 32'(nr), 32'd0);
    enq(1'b0, 3'd6, 32'h38, 32'd0);
    @(negedge clk);
    wait_cdb(cyc, reads, read_at);
    check("fl_after_latency", 32'(cyc), 32'd4);
    tick();
    // async reset while a load waits behind a stalled CDB slot
    cdb_ready = 1'b0;
    ready_en = 1'b0;
    for (int i = 0; i < 4; i++) enq(1'b0, 3'(i), 32'h40 + 32'(4 * i), 32'd0);
    ready_en = 1'b1;
    wait_blocked();
    tick();
    enq(1'b0, 3'd4, 32'h50, 32'd0);
    enq(1'b0, 3'd5, 32'h54, 32'd0);
    @(negedge clk);
    check("rs_full", 32'(enq_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rs_mem_valid", 32'(mem_valid), 32'd0);
    check("rs_mem_read", 32'(mem_read), 32'd0);
    check("rs_enq_ready", 32'(enq_ready), 32'd1);
    check("rs_mem_ls", 32'(mem_ls), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    cdb_ready = 1'b1;
    tick();
    // randomized traffic, ROB head follows program order
    auto_head = 1'b1;
    next_rob = '0;
    for (int n = 0; n < 400; n++) begin
      if (!enq_valid && $urandom_range(0, 99) < 60) begin
        enq_valid = 1'b1;
        enq_is_store = $urandom_range(0, 99) < 35;
        enq_rob = next_rob;
        enq_addr = 32'($urandom_range(0, 7)) << 2;
        enq_data = $urandom;
      end
      cdb_ready = $urandom_range(0, 99) < 70;
      ready_en = $urandom_range(0, 99) < 80;
      @(negedge clk);
      acc = enq_valid && enq_ready;
      tick();
      if (acc) begin
        enq_valid = 1'b0;
        next_rob = next_rob + 3'd1;
      end
    end
    enq_valid = 1'b0;
    cdb_ready = 1'b1;
    ready_en = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || pend.size() != 0); i++) tick();
    check("drain_results", 32'(exp_q.size()), 32'd0);
    check("drain_pending", 32'(pend.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/load_store_queue.md
# load_store_queue

In-order load/store queue that sits between dispatch and `memory_unit` and acts as the initiator of the memory-unit request protocol. It buffers memory ops in program order and issues loads freely but stores only when they reach the ROB head. It holds the memory-side request stable while a load is outstanding, then collects the load result and presents it to the CDB/ROB with a valid/ready handshake. On mispredict flush it empties the queue and drains any in-flight load.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `ROB_IX_W`, 3: ROB index width.
- `clk_in` in 1: single clock, all state on rising edge.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `enq_valid_in` in 1: dispatch presents an op.
- `enq_is_store_in` in 1: 1 = STORE, 0 = LOAD.
- `enq_rob_ix_in` in ROB_IX_W: ROB index of the op.
- `enq_addr_in` in 32: byte address (already computed).
- `enq_data_in` in 32: store data; ignored for loads.
- `enq_ready_out` out 1: queue not full.
- `rob_head_ix_in` in ROB_IX_W: ROB index currently at commit head.
- `flush_in` in 1: mispredict; discard all queued and in-flight ops.
- `mem_valid_out` out 1: request to memory unit (its `valid_in`).
- `mem_ready_in` in 1: memory unit `ready_out`.
- `mem_load_or_store_out` out 1: 0 = LOAD, 1 = STORE.
- `mem_load_rob_ix_out` out ROB_IX_W: load ROB index.
- `mem_load_addr_out` out 32, `mem_store_addr_out` out 32, `mem_store_data_out` out 32.
- `mem_result_valid_in` in 1: memory unit `valid_out`.
- `mem_result_rob_ix_in` in ROB_IX_W, `mem_result_data_in` in 32: load result.
- `mem_read_out` out 1: consume load result (memory unit `read_in`).
- `cdb_valid_out` out 1, `cdb_rob_ix_out` out ROB_IX_W, `cdb_data_out` out 32: load result to CDB.
- `cdb_ready_in` in 1: CDB accepts result.

## Operation
- Circular buffer: head/tail pointers `$clog2(DEPTH)` bits plus one wrap bit; empty when pointers equal; full when indices equal and wrap bits differ.
- Enqueue when `enq_valid_in && enq_ready_out && !flush_in`. `enq_ready_out = !full`; no same-cycle dequeue bypass when full.
- FSM states: IDLE, LOAD_WAIT, DRAIN.
- IDLE, queue non-empty: `mem_valid_out = 1` if head is LOAD, or head is STORE and `head.rob_ix == rob_head_ix_in`. Request fires on `mem_valid_out && mem_ready_in`.
- IDLE, mem outputs: driven combinationally from the head entry. `mem_load_or_store_out = head.is_store`, or 0 when empty.
- STORE fire: dequeue; stay IDLE.
- LOAD fire: dequeue; latch addr/rob_ix into hold registers; go to LOAD_WAIT.
- LOAD_WAIT/DRAIN, mem outputs: `mem_valid_out = 0`, `mem_load_or_store_out = 0`; addr/rob_ix driven from hold registers. The memory unit keeps sampling the address until its result is read.
- LOAD_WAIT: the result slot is free when `!cdb_valid_out || cdb_ready_in`. If `mem_result_valid_in` and the slot is free:
  - assert `mem_read_out` combinationally the same cycle;
  - register rob_ix/data into the CDB slot and set `cdb_valid_out`;
  - go to IDLE.
- CDB slot: `cdb_valid_out` clears on `cdb_ready_in` unless refilled the same cycle.
- DRAIN: on `mem_result_valid_in`, assert `mem_read_out`, discard the data, go to IDLE.
- Flush:
  - pointers reset, queue empty, `cdb_valid_out` cleared; a same-cycle enqueue is dropped.
  - In LOAD_WAIT, or if a load fires the same cycle, go to DRAIN.
  - A store firing in the flush cycle completes (it was committed).
  - In DRAIN, flush has no further effect.

## Timing
- Reset values: all pointers 0, state IDLE, `cdb_valid_out` 0, hold regs 0.
- Outputs under reset: `mem_valid_out` 0, `mem_read_out` 0, `enq_ready_out` 1.
- Enqueued entry is visible at the head the cycle after enqueue. Earliest fire is one cycle after enqueue.
- Store: one cycle from fire to dequeue; one store per cycle max.
- Load: fire at cycle N. `memory_unit` result valid at N+3. With the slot free, `cdb_valid_out` rises at N+4 and state returns to IDLE at N+4. The next op may fire at N+4.
- Backpressure: while `cdb_valid_out && !cdb_ready_in`, the load result waits in memory and `mem_read_out` stays 0.
- Reset asserted mid-LOAD_WAIT: immediate return to reset values. The memory unit is reset by the same reset.

## Test plan
- Reset, then enqueue LOAD rob 2 addr 0x8, with mem[2] = 0x1234. Expect fire next cycle; `cdb_valid_out` with rob 2, data 0x1234, 4 cycles after fire; `mem_read_out` pulses 1 cycle.
- Enqueue STORE rob 5 addr 0x4 data 0xAA with `rob_head_ix_in` = 3 for 3 cycles, then 5. Expect no `mem_valid_out` until the head matches; then a single-cycle store fire. A following LOAD 0x4 returns 0xAA.
- Enqueue 4 LOADs with `mem_ready_in` held 0. Expect `enq_ready_out` = 0 after the 4th; a 5th enqueue is rejected. Results emerge in order as rob 0,1,2,3 once ready is released, including pointer wrap.
- Load result with `cdb_ready_in` = 0 for 5 cycles. Expect `mem_read_out` = 0 until the slot frees, then data delivered once, no duplicate.
- `flush_in` 1 cycle after a load fire with 2 entries queued. Expect state DRAIN, `mem_read_out` pulse at result, no `cdb_valid_out`, queue empty, `enq_ready_out` = 1.
- Async reset (`rst_n_in` low mid-cycle) during LOAD_WAIT. Expect all outputs at reset values immediately, with no clock edge required.
